// File: rtl/pcgen_if.sv
// Shared core width and the AXI-Stream style handshake bundle used between fetch stages.
// Data moves only in a cycle where tvalid and tready are both high.
package offnariscv_pkg;
    localparam int unsigned XLEN = 32;
endpackage

interface axis_if #(
    parameter int unsigned TDATA_WIDTH = 32
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;

    modport m (output tdata, output tvalid, input tready);
    modport s (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pcgen.sv
// Fetch PC generator: registered next PC, redirects land one cycle after acceptance.
// Offer is held under back-pressure; redirects are never back-pressured and replace the offer.
module pcgen #(
    parameter int unsigned XLEN = offnariscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic        clk,
    input  logic        rst,
    axis_if.m           pcgif_axis_if,
    axis_if.s           current_pc_axis_if,
    axis_if.s           redirect_axis_if,
    output logic        invalidate,
    output logic        redirect_misaligned,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            misalign_q, misalign_d;
    logic [31:0]     fetch_count_q, fetch_count_d;

    logic            pc_hs;
    logic            redir_hs;
    logic [XLEN-1:0] redir_target;
    logic            current_pc_unused;

    // The current-PC channel is an always-ready sink reserved for a future BTB; its payload is not consumed.
    assign current_pc_axis_if.tready = 1'b1;
    assign current_pc_unused = ^{current_pc_axis_if.tdata, current_pc_axis_if.tvalid};

    assign redirect_axis_if.tready = !rst;

    // Offer is a pure function of registered state, so tready never reaches tvalid/tdata.
    assign pcgif_axis_if.tvalid = 1'b1;
    assign pcgif_axis_if.tdata  = (state_q == FLUSH) ? target_q : next_pc_q;

    assign pc_hs        = pcgif_axis_if.tvalid && pcgif_axis_if.tready;
    assign redir_hs     = redirect_axis_if.tvalid && redirect_axis_if.tready;
    assign redir_target = {redirect_axis_if.tdata[XLEN-1:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        next_pc_d     = next_pc_q;
        target_d      = target_q;
        misalign_d    = redir_hs && (redirect_axis_if.tdata[1:0] != 2'b00);
        fetch_count_d = pc_hs ? fetch_count_q + 32'd1 : fetch_count_q;

        unique case (state_q)
            RUN: begin
                // A redirect wins; the increment of the stale PC is dropped.
                if (redir_hs) begin
                    target_d = redir_target;
                    state_d  = FLUSH;
                end else if (pc_hs) begin
                    next_pc_d = next_pc_q + XLEN'(4);
                end
            end
            FLUSH: begin
                if (redir_hs) begin
                    target_d = redir_target;
                end else if (pc_hs) begin
                    next_pc_d = target_q + XLEN'(4);
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Fetch unit fetches RESET_VECTOR itself, so the first offer is the following word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            next_pc_q     <= RESET_VECTOR + XLEN'(4);
            target_q      <= '0;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            next_pc_q     <= next_pc_d;
            target_q      <= target_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign invalidate          = (state_q == FLUSH);
    assign redirect_misaligned = misalign_q;
    assign fetch_count         = fetch_count_q;

endmodule

// File: tb/tb_pcgen.sv
// Self-checking bench for pcgen: directed vector table plus randomized run against a reference model.
module tb_pcgen;

    localparam logic [31:0] RV = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        invalidate;
    logic        redirect_misaligned;
    logic [31:0] fetch_count;

    axis_if #(.TDATA_WIDTH(32)) pcg ();
    axis_if #(.TDATA_WIDTH(32)) cur ();
    axis_if #(.TDATA_WIDTH(32)) red ();

    pcgen #(.RESET_VECTOR(RV)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pcgif_axis_if       (pcg),
        .current_pc_axis_if  (cur),
        .redirect_axis_if    (red),
        .invalidate          (invalidate),
        .redirect_misaligned (redirect_misaligned),
        .fetch_count         (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the offered address advances by one word once accepted,
    // and a redirect replaces the offer with its word-aligned target.
    logic [31:0] m_offer;
    bit          m_flushing;
    bit          m_mis;
    logic [31:0] m_cnt;

    typedef struct {
        bit          r;
        bit          rdy;
        bit          rv;
        logic [31:0] rd;
        logic [31:0] e_tdata;
        bit          e_inv;
        bit          e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit rdy, bit rv, logic [31:0] rd,
                                logic [31:0] et, bit ei, bit em, logic [31:0] ec);
        vec_t v;
        v.r = r; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_tdata = et; v.e_inv = ei; v.e_mis = em; v.e_cnt = ec;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit rdy, input bit rv, input logic [31:0] rd);
        if (r) begin
            m_offer = RV + 32'd4;
            m_flushing = 1'b0;
            m_mis = 1'b0;
            m_cnt = 32'd0;
        end else begin
            m_mis = rv && (rd % 4 != 0);
            if (rdy) m_cnt = m_cnt + 32'd1;
            if (rv) begin
                m_offer = rd - (rd % 4);
                m_flushing = 1'b1;
            end else if (rdy) begin
                m_offer = m_offer + 32'd4;
                m_flushing = 1'b0;
            end
        end
    endtask

    task automatic step(input bit r, input bit rdy, input bit rv, input logic [31:0] rd);
        @(negedge clk);
        rst = r;
        pcg.tready = rdy;
        red.tvalid = rv;
        red.tdata = rd;
        #1;
        chk("redirect_tready", {31'd0, red.tready}, {31'd0, !r});
        @(posedge clk);
        model_update(r, rdy, rv, rd);
        #2;
        chk("model_tvalid", {31'd0, pcg.tvalid}, 32'd1);
        chk("model_tdata", pcg.tdata, m_offer);
        chk("model_invalidate", {31'd0, invalidate}, {31'd0, m_flushing});
        chk("model_misaligned", {31'd0, redirect_misaligned}, {31'd0, m_mis});
        chk("model_fetch_count", fetch_count, m_cnt);
    endtask

    initial begin
        rst = 1'b1;
        pcg.tready = 1'b0;
        red.tvalid = 1'b0;
        red.tdata = '0;
        cur.tvalid = 1'b1;
        cur.tdata = 32'hDEAD_BEEF;

        // reset with a concurrent redirect that must be ignored, then sequential run
        add(1, 0, 1, 32'h9000, 32'h1004, 0, 0, 0);
        add(0, 1, 0, 0, 32'h1008, 0, 0, 1);
        add(0, 1, 0, 0, 32'h100C, 0, 0, 2);
        add(0, 1, 0, 0, 32'h1010, 0, 0, 3);
        add(0, 1, 0, 0, 32'h1014, 0, 0, 4);
        // back-pressure at 0x1008
        add(1, 0, 0, 0, 32'h1004, 0, 0, 0);
        add(0, 1, 0, 0, 32'h1008, 0, 0, 1);
        add(0, 0, 0, 0, 32'h1008, 0, 0, 1);
        add(0, 0, 0, 0, 32'h1008, 0, 0, 1);
        add(0, 0, 0, 0, 32'h1008, 0, 0, 1);
        // redirect while stalled, released two cycles later
        add(0, 0, 1, 32'h2000, 32'h2000, 1, 0, 1);
        add(0, 0, 0, 0, 32'h2000, 1, 0, 1);
        add(0, 0, 0, 0, 32'h2000, 1, 0, 1);
        add(0, 1, 0, 0, 32'h2004, 0, 0, 2);
        add(0, 1, 0, 0, 32'h2008, 0, 0, 3);
        // redirect coinciding with a RUN handshake, then a second redirect in FLUSH
        add(1, 0, 0, 0, 32'h1004, 0, 0, 0);
        add(0, 1, 0, 0, 32'h1008, 0, 0, 1);
        add(0, 1, 1, 32'h3000, 32'h3000, 1, 0, 2);
        add(0, 0, 1, 32'h4000, 32'h4000, 1, 0, 2);
        add(0, 1, 0, 0, 32'h4004, 0, 0, 3);
        // misaligned redirect and address wrap (FLUSH and RUN)
        add(0, 0, 1, 32'h5002, 32'h5000, 1, 1, 3);
        add(0, 0, 0, 0, 32'h5000, 1, 0, 3);
        add(0, 1, 0, 0, 32'h5004, 0, 0, 4);
        add(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 4);
        add(0, 1, 0, 0, 32'h0000_0000, 0, 0, 5);
        add(0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 0, 5);
        add(0, 1, 0, 0, 32'hFFFF_FFFC, 0, 0, 6);
        add(0, 1, 0, 0, 32'h0000_0000, 0, 0, 7);
        // reset while flushing toward 0x6000
        add(0, 0, 1, 32'h6000, 32'h6000, 1, 0, 7);
        add(1, 0, 0, 0, 32'h1004, 0, 0, 0);
        add(0, 0, 0, 0, 32'h1004, 0, 0, 0);
        add(0, 1, 0, 0, 32'h1008, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].rdy, vecs[i].rv, vecs[i].rd);
            chk($sformatf("vec%0d_tdata", i), pcg.tdata, vecs[i].e_tdata);
            chk($sformatf("vec%0d_invalidate", i), {31'd0, invalidate}, {31'd0, vecs[i].e_inv});
            chk($sformatf("vec%0d_misaligned", i), {31'd0, redirect_misaligned}, {31'd0, vecs[i].e_mis});
            chk($sformatf("vec%0d_fetch_count", i), fetch_count, vecs[i].e_cnt);
        end

        // randomized traffic, including unaligned targets and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0,
                 $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcgen.md
PCGEN -- requirements
Module: pcgen

Interface
REQ-001 Parameter: RESET_VECTOR, default 0, address of the first instruction; must match the instruction fetch unit's RESET_VECTOR.
REQ-002 Parameter: XLEN, taken from offnariscv_pkg, datapath and PC width (32).
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: pcgif_axis_if  axis_if.m  TDATA_WIDTH=XLEN  next fetch PC offered to the instruction fetch unit.
REQ-006 Port: current_pc_axis_if  axis_if.s  TDATA_WIDTH=XLEN  PC currently held by the fetch unit; sink only, tready tied 1, tdata ignored (reserved for a future BTB).
REQ-007 Port: redirect_axis_if  axis_if.s  TDATA_WIDTH=XLEN  redirect target from execute/commit (mispredict, trap, fence.i).
REQ-008 Port: invalidate  output  1  flush request to the IF/ID skid buffer.
REQ-009 Port: redirect_misaligned  output  1  one-cycle pulse: the accepted redirect target had bits[1:0] != 0.
REQ-010 Port: fetch_count  output  32  count of pcgif_axis_if handshakes since reset.

Function
REQ-011 Registers: next_pc_q (XLEN), state_q in {RUN, FLUSH}, target_q (XLEN), misalign_q (1), fetch_count_q (32).
REQ-012 pcgif_axis_if.tvalid = 1 in both states; tdata = next_pc_q in RUN and target_q in FLUSH.
REQ-013 Hold rule: tdata stays stable while tvalid && !tready, except when a redirect replaces it.
REQ-014 redirect_axis_if.tready = 1 in every cycle outside reset; a redirect is never back-pressured.
REQ-015 RUN, pcgif handshake, no redirect: next_pc_q <= next_pc_q + 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0x00000000).
REQ-016 RUN, redirect handshake: target_q <= {tdata[XLEN-1:2], 2'b00}; state -> FLUSH; this takes priority over any same-cycle pcgif handshake, and the stale PC's increment is discarded.
REQ-017 FLUSH, pcgif handshake, no redirect: next_pc_q <= target_q + 4; state -> RUN.
REQ-018 FLUSH, redirect handshake: target_q is overwritten with the new aligned target; state stays FLUSH, including when a pcgif handshake occurs in the same cycle.
REQ-019 invalidate = (state_q == FLUSH), combinational from state. It is therefore asserted from the cycle after the redirect through the cycle in which the target is handshaken, and deasserted the following cycle.
REQ-020 redirect_misaligned: registered; equals 1 exactly in the cycle after a redirect handshake whose tdata[1:0] != 0, otherwise 0.
REQ-021 fetch_count_q increments by 1 on every pcgif handshake in either state and wraps from 0xFFFFFFFF to 0.
REQ-022 Combinational paths: none from pcgif_axis_if.tready to pcgif_axis_if.tvalid or tdata.

Reset
REQ-023 While rst = 1, the next clock edge sets: next_pc_q = RESET_VECTOR + 4, state_q = RUN, target_q = 0, misalign_q = 0, fetch_count_q = 0.
REQ-024 The RESET_VECTOR + 4 reset value holds because the fetch unit itself fetches RESET_VECTOR out of reset.
REQ-025 Outputs after a reset edge: pcgif tvalid = 1 and tdata = RESET_VECTOR + 4; invalidate = 0; redirect_misaligned = 0; fetch_count = 0.
REQ-026 Reset during FLUSH discards the pending target; no invalidate is asserted in the cycle after reset.
REQ-027 A redirect presented in the same cycle as rst = 1 is ignored.

Verification
REQ-028 Sequential run: RESET_VECTOR = 0x1000, tready = 1 for 4 cycles after reset -> tdata 0x1004, 0x1008, 0x100C, 0x1010; fetch_count = 4.
REQ-029 Back-pressure: tready = 0 for 3 cycles at tdata = 0x1008 -> tdata holds 0x1008, next_pc_q unchanged, fetch_count unchanged.
REQ-030 Redirect with stall: redirect 0x2000 while tready = 0, then tready = 1 after 2 cycles -> invalidate = 1 for 3 cycles, tdata = 0x2000 at handshake, then 0x2004; invalidate = 0 afterwards.
REQ-031 Simultaneous events: redirect 0x3000 in the same cycle as a RUN handshake of 0x1008 -> next offered tdata = 0x3000, never 0x100C. Second redirect 0x4000 during FLUSH -> tdata becomes 0x4000, 0x3000 is never handshaken.
REQ-032 Misaligned target and wrap: redirect 0x5002 -> tdata 0x5000 and redirect_misaligned pulses exactly 1 cycle. Redirect 0xFFFFFFFC followed by a handshake -> next tdata = 0x00000000.
REQ-033 Reset mid-FLUSH: rst asserted while state = FLUSH with target 0x6000 -> after reset tdata = RESET_VECTOR + 4, invalidate = 0, 0x6000 is never offered.
